// File: rtl/lstm_seq_driver.sv
// LSTM node initiator: buffers gate quadruples in a FIFO, issues one timestep
// at a time to an LSTM_node, feeds h_t back as recurrent input and streams it out.
module lstm_seq_driver #(
  parameter int         DW        = 16,
  parameter int         DEPTH     = 8,
  parameter int         LEN_W     = 8,
  parameter int         TIMEOUT   = 64,
  parameter logic [1:0] RUN_CODE  = 2'b01,
  parameter logic [1:0] IDLE_CODE = 2'b00,
  parameter logic [1:0] DONE_CODE = 2'b11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*DW-1:0]  in_gates,
  output logic [DW-1:0]    node_in_i,
  output logic [DW-1:0]    node_in_c,
  output logic [DW-1:0]    node_in_f,
  output logic [DW-1:0]    node_in_o,
  output logic [DW-1:0]    node_recu_in,
  output logic [1:0]       node_status_in,
  input  logic [1:0]       node_status_out,
  input  logic [DW-1:0]    node_out,
  input  logic [DW-1:0]    node_recu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [LEN_W-1:0] out_step,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                  state;
  logic [DEPTH-1:0][4*DW-1:0]  mem;
  logic [AW:0]                 wptr, rptr;
  logic                        full, empty, push, pop;
  logic [LEN_W-1:0]            len_q, step, step_nx;
  logic [DW-1:0]               h_prev;
  logic [TW-1:0]               tcnt;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == S_ISSUE) && !empty;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign out_step = step;
  assign step_nx  = step + LEN_W'(1);

  always_ff @(posedge clock)
    if (push) mem[wptr[AW-1:0]] <= in_gates;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      len_q          <= '0;
      step           <= '0;
      h_prev         <= '0;
      tcnt           <= '0;
      node_in_i      <= '0;
      node_in_c      <= '0;
      node_in_f      <= '0;
      node_in_o      <= '0;
      node_recu_in   <= '0;
      node_status_in <= IDLE_CODE;
      out_valid      <= 1'b0;
      out_data       <= '0;
      error          <= 1'b0;
    end else begin
      // RUN is a single-cycle launch; every other cycle drives IDLE.
      node_status_in <= IDLE_CODE;
      case (state)
        S_IDLE: if (start) begin
          error  <= 1'b0;
          len_q  <= seq_len;
          step   <= '0;
          h_prev <= '0;
          state  <= (seq_len == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (!empty) begin
          {node_in_i, node_in_c, node_in_f, node_in_o} <= mem[rptr[AW-1:0]];
          node_recu_in   <= h_prev;
          node_status_in <= RUN_CODE;
          tcnt           <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          // A DONE arriving on the expiry cycle still wins over the timeout.
          if (node_status_out == DONE_CODE) begin
            out_data  <= node_out;
            h_prev    <= node_recu_out;
            out_valid <= 1'b1;
            state     <= S_CAPT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_CAPT: if (out_ready) begin
          out_valid <= 1'b0;
          step      <= step_nx;
          state     <= (step_nx == len_q) ? S_DONE : S_ISSUE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
